// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmit path.
// Build option: UART_TX_PARITY_EN adds a PARITY state (8E1 framing).
// Holds the frame state encoding, data width and the baud divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  // Integer clock cycles per serial bit; callers keep the result >= 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// Latency: bit_done is high during the final cycle of each bit period.
// Backpressure: none; clr restarts the period synchronously.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done = (cnt_q == LAST);

  // Wrap at the end of each bit, or restart whenever the frame FSM asks.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_done) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: DEPTH-entry byte FIFO drained onto an 8N1 line (8E1 with UART_TX_PARITY_EN).
// Latency: write at edge N into an idle, empty buffer pops at N+1; tx falls right after that edge.
// Backpressure: none on the host; writes while full are dropped and latch the sticky overflow flag.
`timescale 1ns/1ps
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 10_000_000,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int CNT_W        = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 ovf_q,    ovf_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Frame FSM
  tx_state_t            state_q,   state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                 tx_q,      tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q,  parity_d;
`endif
  logic                 bit_done;
  logic                 baud_clr;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign head     = mem_q[rd_ptr_q];

  // A full FIFO drops the write even if the same edge pops an entry.
  assign push = wr_en && !full;

  // Bit timer restarts on every state change and is parked at zero while idle.
  assign baud_clr = (state_q == IDLE) || (state_d != state_q);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  // FIFO pointer/count/overflow next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q || (wr_en && full);
  end

  // Frame sequencing: pop, start bit, 8 data bits LSB first, [parity], stop bit.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          shreg_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            // Chain straight into the next start bit: no idle gap.
            pop      = 1'b1;
            shreg_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control state; reset aborts any frame and forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed scenarios plus randomized traffic against a frame-level model.
// Latency: model counts edges; a frame occupies NBITS*CPB cycles starting at the pop edge.
// Backpressure: model drops writes seen while it holds DEPTH bytes and latches overflow.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx, busy, full, empty, overflow;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  // Reference model state: queued bytes, popped bytes, frame in flight.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] rxq[$];
  logic [7:0] m_cur;
  bit         m_busy;
  bit         m_ovf;
  int         cyc;
  int         fr_start;

  uart_tx_buffered #(
    .CLK_FREQ(100_000_000),
    .BAUD    (10_000_000),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line receiver: samples each bit at its centre, records the data byte.
  initial begin : line_mon
    logic [7:0] d;
    d = 8'h00;
    forever begin
      @(negedge tx);
      if (rst !== 1'b1) begin
        #55;
        for (int i = 0; i < 8; i++) begin
          #100;
          d[i] = tx;
        end
        #(100 * (NBITS - 9));
        rxq.push_back(d);
      end
    end
  end

  task automatic model_reset();
    mq.delete();
    m_busy   = 1'b0;
    m_ovf    = 1'b0;
    cyc      = 0;
    fr_start = 0;
  endtask

  // One clock edge of the abstract transmitter.
  task automatic model_edge(input logic we, input logic [7:0] d);
    int pre;
    bit do_pop;
    cyc++;
    pre    = mq.size();
    do_pop = 1'b0;
    if (!m_busy) begin
      do_pop = (pre > 0);
    end else if (cyc - fr_start == FRAME) begin
      if (pre > 0) do_pop = 1'b1;
      else         m_busy = 1'b0;
    end
    if (do_pop) begin
      m_cur    = mq.pop_front();
      sent.push_back(m_cur);
      fr_start = cyc;
      m_busy   = 1'b1;
    end
    if (we) begin
      if (pre == DEPTH) m_ovf = 1'b1;
      else              mq.push_back(d);
    end
  endtask

  // Expected line level from the bit-time position inside the current frame.
  function automatic logic exp_tx();
    int b;
    if (!m_busy) return 1'b1;
    b = (cyc - fr_start) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (NBITS == 11 && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  task automatic tick(input logic we, input logic [7:0] d);
    @(negedge clk);
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    if (rst !== 1'b1) model_edge(we, d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic want;
    rxq.delete(); sent.delete();
    tick(1'b1, 8'h55);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_write_edge_tx: got %b want 1", tx); end
    tick(1'b0, 8'h00);
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_start: tx=%b busy=%b want 0/1", tx, busy); end
    for (int j = 1; j < FRAME; j++) begin
      tick(1'b0, 8'h00);
      if (j < 9 * CPB) begin
        want = ((j / CPB) % 2) == 1;
        checks++; if (tx !== want) begin errors++; $display("FAIL single_pattern j=%0d: got %b want %b", j, tx, want); end
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b want 1", busy); end
    tick(1'b0, 8'h00);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_busy_fall: busy=%b tx=%b want 0/1", busy, tx); end
    #50;
    checks++; if (rxq.size() != 1 || rxq[0] !== 8'h55) begin errors++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte 55", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx); end
  endtask

  task automatic test_burst();
    logic [7:0] bytes [3];
    int busy_cyc;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    rxq.delete(); sent.delete();
    busy_cyc = 0;
    for (int i = 0; i < 3 * FRAME + 20; i++) begin
      if (i < 3) tick(1'b1, bytes[i]);
      else       tick(1'b0, 8'h00);
      if (busy === 1'b1) busy_cyc++;
      checks++; if (tx !== exp_tx()) begin errors++; $display("FAIL burst_tx cyc=%0d: got %b want %b", i, tx, exp_tx()); end
    end
    checks++; if (busy_cyc != 3 * FRAME) begin errors++; $display("FAIL burst_busy_len: got %0d want %0d", busy_cyc, 3 * FRAME); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL burst_empty: got %b want 1", empty); end
    #50;
    checks++; if (rxq.size() != 3) begin errors++; $display("FAIL burst_rx_count: got %0d want 3", rxq.size()); end
    for (int i = 0; i < 3 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== bytes[i]) begin errors++; $display("FAIL burst_rx[%0d]: got %h want %h", i, rxq[i], bytes[i]); end
    end
  endtask

  task automatic test_overflow();
    int max_cnt;
    rxq.delete(); sent.delete();
    max_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(i + 1));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    tick(1'b0, 8'h00);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (max_cnt != 4)      begin errors++; $display("FAIL ovf_peak_count: got %0d want 4", max_cnt); end
    for (int i = 0; i < 5 * FRAME + 20; i++) begin
      tick(1'b0, 8'h00);
      checks++; if (tx !== exp_tx() || count !== 3'(mq.size())) begin errors++; $display("FAIL ovf_line cyc=%0d: tx=%b count=%0d want %b/%0d", i, tx, count, exp_tx(), mq.size()); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    #50;
    checks++; if (rxq.size() != 5) begin errors++; $display("FAIL ovf_rx_count: got %0d want 5", rxq.size()); end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_rx[%0d]: got %h want %h", i, rxq[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 8'hC3);
    tick(1'b0, 8'h00);
    repeat (4 * CPB + 5) tick(1'b0, 8'h00);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_bit3_before: got %b want 0", tx); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (count !== 3'd0)    begin errors++; $display("FAIL midrst_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1500;
    rxq.delete(); sent.delete();
    for (int i = 0; i < 300; i++) begin
      tick(1'b0, 8'h00);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet cyc=%0d: tx=%b busy=%b want 1/0", i, tx, busy); end
    end
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL midrst_no_frame: got %0d bytes want 0", rxq.size()); end
  endtask

  task automatic test_random();
    int rate;
    int guard;
    logic we;
    rxq.delete(); sent.delete();
    for (int i = 0; i < 1800; i++) begin
      rate = (i < 600) ? 2 : (i < 1200) ? 25 : 1;
      we   = ($urandom_range(0, 99) < rate);
      tick(we, 8'($urandom));
      checks++;
      if (tx !== exp_tx() || busy !== m_busy || count !== 3'(mq.size()) ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random cyc=%0d: tx=%b busy=%b count=%0d full=%b empty=%b ovf=%b want %b/%b/%0d/%b/%b/%b",
                 i, tx, busy, count, full, empty, overflow, exp_tx(), m_busy, mq.size(),
                 mq.size() == DEPTH, mq.size() == 0, m_ovf);
      end
    end
    guard = 0;
    while ((m_busy || mq.size() != 0) && guard < 10 * FRAME) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    checks++; if (guard >= 10 * FRAME) begin errors++; $display("FAIL random_drain_timeout: got %0d cycles want < %0d", guard, 10 * FRAME); end
    #200;
    checks++; if (rxq.size() != sent.size()) begin errors++; $display("FAIL random_rx_count: got %0d want %0d", rxq.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < rxq.size(); i++) begin
      checks++; if (rxq[i] !== sent[i]) begin errors++; $display("FAIL random_rx[%0d]: got %h want %h", i, rxq[i], sent[i]); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic want;
    tick(1'b1, 8'h07);
    tick(1'b0, 8'h00);
    for (int j = 1; j < FRAME; j++) begin
      tick(1'b0, 8'h00);
      if (j >= 8 * CPB) begin
        want = (j >= 9 * CPB);
        checks++; if (tx !== want) begin errors++; $display("FAIL parity_tail j=%0d: got %b want %b", j, tx, want); end
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL parity_busy_last: got %b want 1", busy); end
    tick(1'b0, 8'h00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_frame_len: busy=%b want 0", busy); end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_mid_reset();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
